if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/pc_register.sv | 33 +++
 rtl/if_stage.sv | 157 +++++++++++++++
 tb/tb_if_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: PC width default, NOP encoding, fetch FSM states
// and the next-PC select used by the PC register.
package pipeline_pkg;

  localparam int          PC_W_DEFAULT = 9;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    KILL,
    HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_TARGET
  } pc_sel_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with hold / +4 / redirect-target selection.
// Latency: new PC visible one edge after sel; no backpressure (sel=PC_HOLD freezes it).
module pc_register
  import pipeline_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_next;

  // +4 wraps naturally at PC_W bits
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:    pc_next = pc + PC_W'(4);
      PC_TARGET: pc_next = target;
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, IF/ID register, skid buffer for stalled responses.
// Latency: instruction on IF/ID one edge after rvalid; Stall holds PC and IF/ID, PcSel overrides Stall.
// Optional IFETCH_PERF_EN adds PerfFetched/PerfKilled counters.
module if_stage
  import pipeline_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] IfPc,
  output logic [31:0]     IfInstr,
  output logic            IfValid
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     PerfFetched,
  output logic [31:0]     PerfKilled
`endif
);

  fetch_state_t    state, state_next;
  pc_sel_t         pc_sel;
  logic [PC_W-1:0] pc, target;
  logic [31:0]     skid, deliver_instr;
  logic            deliver, load_skid, discard;
  logic            unused_brpc;

  assign target      = {BrPC[PC_W-1:2], 2'b00};
  assign imem_addr   = pc;
  assign unused_brpc = ^BrPC;

  pc_register #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (pc_sel),
    .target (target),
    .pc     (pc)
  );

  always_comb begin
    state_next    = state;
    pc_sel        = PC_HOLD;
    imem_req      = 1'b0;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    load_skid     = 1'b0;
    discard       = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (PcSel) begin
          pc_sel = PC_TARGET;
          if (imem_gnt) state_next = KILL;
        end else if (imem_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (PcSel) begin
            discard    = 1'b1;
            pc_sel     = PC_TARGET;
            state_next = REQ;
          end else if (!Stall) begin
            deliver    = 1'b1;
            pc_sel     = PC_INC;
            state_next = REQ;
          end else begin
            load_skid  = 1'b1;
            state_next = HOLD;
          end
        end else if (PcSel) begin
          pc_sel     = PC_TARGET;
          state_next = KILL;
        end
      end
      // the in-flight response belongs to a stale PC; track redirects until it lands
      KILL: begin
        if (PcSel) pc_sel = PC_TARGET;
        if (imem_rvalid) begin
          discard    = 1'b1;
          state_next = REQ;
        end
      end
      HOLD: begin
        if (PcSel) begin
          discard    = 1'b1;
          pc_sel     = PC_TARGET;
          state_next = REQ;
        end else if (!Stall) begin
          deliver       = 1'b1;
          deliver_instr = skid;
          pc_sel        = PC_INC;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         skid <= '0;
    else if (load_skid) skid <= imem_rdata;
  end

  // redirect flushes to a bubble even while decode is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IfPc    <= '0;
      IfInstr <= NOP;
      IfValid <= 1'b0;
    end else if (PcSel) begin
      IfInstr <= NOP;
      IfValid <= 1'b0;
    end else if (!Stall) begin
      if (deliver) begin
        IfPc    <= pc;
        IfInstr <= deliver_instr;
        IfValid <= 1'b1;
      end else begin
        IfInstr <= NOP;
        IfValid <= 1'b0;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PerfFetched <= '0;
      PerfKilled  <= '0;
    end else begin
      if (deliver) PerfFetched <= PerfFetched + 32'd1;
      if (discard) PerfKilled  <= PerfKilled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the corner cases, then random
// traffic against a transaction-level fetch model.
module tb_if_stage;

  localparam int          PW  = 9;
  localparam logic [PW-1:0] RPC = '0;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Stall = 1'b0, PcSel = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0]   BrPC = '0, imem_rdata = '0;
  logic          imem_req, IfValid;
  logic [PW-1:0] imem_addr, IfPc;
  logic [31:0]   IfInstr;
`ifdef IFETCH_PERF_EN
  logic [31:0]   PerfFetched, PerfKilled;
`endif

  int tests = 0;
  int fails = 0;

  if_stage #(.PC_W(PW), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Stall       (Stall),
    .PcSel       (PcSel),
    .BrPC        (BrPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .IfPc        (IfPc),
    .IfInstr     (IfInstr),
    .IfValid     (IfValid)
`ifdef IFETCH_PERF_EN
    ,
    .PerfFetched (PerfFetched),
    .PerfKilled  (PerfKilled)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          st, ps;
    logic [31:0]   br;
    logic          gnt, rv;
    logic [31:0]   rd;
    logic          ereq;
    logic [PW-1:0] eaddr;
    logic          ev;
    logic [31:0]   ei;
    logic [PW-1:0] epc;
  } vec_t;

  function automatic vec_t mk(logic st, logic ps, logic [31:0] br, logic gnt, logic rv,
                              logic [31:0] rd, logic ereq, logic [PW-1:0] eaddr,
                              logic ev, logic [31:0] ei, logic [PW-1:0] epc);
    vec_t v;
    v.st = st; v.ps = ps; v.br = br; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.ei = ei; v.epc = epc;
    return v;
  endfunction

  function automatic logic [31:0] word_at(logic [PW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  vec_t vt[$];

  // transaction-level model state
  logic          m_started, m_out, m_stale, m_buf_v, m_ifv, m_req, dlv;
  logic [PW-1:0] m_pc, m_ifpc, old_pc, tgt, p_addr;
  logic [31:0]   m_buf, m_ifi, w;
  int            m_fetch, m_kill, p_cnt;
  logic          p_pend;

  initial begin
    // inputs of one cycle; outputs expected after the following edge
    vt.push_back(mk(0,0,0,      0,0,0,            1,9'h000,0,NOPI,0));
    vt.push_back(mk(0,0,0,      1,0,0,            0,9'h000,0,NOPI,0));
    vt.push_back(mk(0,0,0,      0,1,32'hAAAA0001, 1,9'h004,1,32'hAAAA0001,9'h000));
    vt.push_back(mk(0,0,0,      1,0,0,            0,9'h004,0,NOPI,0));
    vt.push_back(mk(0,1,32'h40, 0,0,0,            0,9'h040,0,NOPI,0));
    vt.push_back(mk(0,0,0,      0,0,0,            0,9'h040,0,NOPI,0));
    vt.push_back(mk(0,0,0,      0,1,32'hDEAD0000, 1,9'h040,0,NOPI,0));
    vt.push_back(mk(0,0,0,      1,0,0,            0,9'h040,0,NOPI,0));
    vt.push_back(mk(0,0,0,      0,1,32'hBBBB0002, 1,9'h044,1,32'hBBBB0002,9'h040));
    vt.push_back(mk(1,0,0,      1,0,0,            0,9'h044,1,32'hBBBB0002,9'h040));
    vt.push_back(mk(1,0,0,      0,1,32'hCCCC0003, 0,9'h044,1,32'hBBBB0002,9'h040));
    vt.push_back(mk(1,0,0,      0,0,0,            0,9'h044,1,32'hBBBB0002,9'h040));
    vt.push_back(mk(1,0,0,      0,0,0,            0,9'h044,1,32'hBBBB0002,9'h040));
    vt.push_back(mk(0,0,0,      0,0,0,            1,9'h048,1,32'hCCCC0003,9'h044));
    vt.push_back(mk(1,1,32'h83, 0,0,0,            1,9'h080,0,NOPI,0));
    vt.push_back(mk(0,1,32'h1FC,1,0,0,            0,9'h1FC,0,NOPI,0));
    vt.push_back(mk(0,0,0,      0,1,32'hEEEE0000, 1,9'h1FC,0,NOPI,0));
    vt.push_back(mk(0,0,0,      1,0,0,            0,9'h1FC,0,NOPI,0));
    vt.push_back(mk(0,0,0,      0,1,32'h12345678, 1,9'h000,1,32'h12345678,9'h1FC));
    vt.push_back(mk(1,0,0,      1,0,0,            0,9'h000,1,32'h12345678,9'h1FC));
    vt.push_back(mk(1,0,0,      0,1,32'h77770000, 0,9'h000,1,32'h12345678,9'h1FC));
    vt.push_back(mk(1,1,32'h10, 0,0,0,            1,9'h010,0,NOPI,0));
    vt.push_back(mk(0,0,0,      1,0,0,            0,9'h010,0,NOPI,0));
    vt.push_back(mk(0,1,32'h20, 0,1,32'h99990000, 1,9'h020,0,NOPI,0));
    vt.push_back(mk(0,0,0,      1,0,0,            0,9'h020,0,NOPI,0));

    repeat (2) @(negedge clk);
    check("reset.req",   32'(imem_req),  32'd0);
    check("reset.addr",  32'(imem_addr), 32'(RPC));
    check("reset.valid", 32'(IfValid),   32'd0);
    check("reset.instr", IfInstr,        NOPI);
    check("reset.ifpc",  32'(IfPc),      32'd0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      Stall = vt[i].st; PcSel = vt[i].ps; BrPC = vt[i].br;
      imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rv; imem_rdata = vt[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d.req", i),   32'(imem_req),  32'(vt[i].ereq));
      check($sformatf("vec%0d.addr", i),  32'(imem_addr), 32'(vt[i].eaddr));
      check($sformatf("vec%0d.valid", i), 32'(IfValid),   32'(vt[i].ev));
      check($sformatf("vec%0d.instr", i), IfInstr,        vt[i].ei);
      if (vt[i].ev) check($sformatf("vec%0d.ifpc", i), 32'(IfPc), 32'(vt[i].epc));
    end
`ifdef IFETCH_PERF_EN
    check("perf.fetched", PerfFetched, 32'd4);
    check("perf.killed",  PerfKilled,  32'd4);
`endif

    // asynchronous reset while a request is outstanding, then a stray response
    Stall = 0; PcSel = 0; BrPC = '0; imem_gnt = 0; imem_rvalid = 0;
    #1 rst_n = 1'b0;
    #1;
    check("arst.req",   32'(imem_req),  32'd0);
    check("arst.addr",  32'(imem_addr), 32'(RPC));
    check("arst.valid", 32'(IfValid),   32'd0);
    check("arst.instr", IfInstr,        NOPI);
    check("arst.ifpc",  32'(IfPc),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("stray.req",   32'(imem_req),  32'd1);
    check("stray.addr",  32'(imem_addr), 32'(RPC));
    check("stray.valid", 32'(IfValid),   32'd0);
`ifdef IFETCH_PERF_EN
    check("stray.killed", PerfKilled, 32'd0);
`endif

    // random traffic against the model; DUT is now requesting at RESET_PC
    m_started = 1; m_out = 0; m_stale = 0; m_buf_v = 0; m_buf = '0;
    m_pc = RPC; m_ifv = 0; m_ifi = NOPI; m_ifpc = '0;
    m_fetch = 0; m_kill = 0; p_pend = 0; p_cnt = 0; p_addr = '0;
    for (int c = 0; c < 2000; c++) begin
      m_req = m_started && !m_out && !m_buf_v;
      check("rnd.req",   32'(imem_req),  32'(m_req));
      check("rnd.addr",  32'(imem_addr), 32'(m_pc));
      check("rnd.valid", 32'(IfValid),   32'(m_ifv));
      check("rnd.instr", IfInstr,        m_ifi);
      if (m_ifv) check("rnd.ifpc", 32'(IfPc), 32'(m_ifpc));

      Stall       = ($urandom_range(3) == 0);
      PcSel       = ($urandom_range(9) == 0);
      BrPC        = $urandom();
      imem_gnt    = m_req && ($urandom_range(2) != 0);
      imem_rvalid = p_pend && (p_cnt == 0);
      imem_rdata  = imem_rvalid ? word_at(p_addr) : $urandom();

      tgt = BrPC[PW-1:0] & ~PW'(3);
      dlv = 0; w = '0; old_pc = m_pc;
      if (!m_started) begin
        m_started = 1;
      end else if (m_buf_v) begin
        if (PcSel) begin m_buf_v = 0; m_kill++; m_pc = tgt; end
        else if (!Stall) begin dlv = 1; w = m_buf; m_buf_v = 0; m_pc = m_pc + PW'(4); end
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_out = 0;
          if (m_stale || PcSel) begin m_kill++; if (PcSel) m_pc = tgt; end
          else if (!Stall) begin dlv = 1; w = imem_rdata; m_pc = m_pc + PW'(4); end
          else begin m_buf = imem_rdata; m_buf_v = 1; end
          m_stale = 0;
        end else if (PcSel) begin
          m_pc = tgt; m_stale = 1;
        end
      end else begin
        if (imem_gnt) begin m_out = 1; m_stale = PcSel; end
        if (PcSel) m_pc = tgt;
      end
      if (PcSel) begin m_ifv = 0; m_ifi = NOPI; end
      else if (!Stall) begin
        if (dlv) begin m_ifv = 1; m_ifi = w; m_ifpc = old_pc; m_fetch++; end
        else begin m_ifv = 0; m_ifi = NOPI; end
      end

      if (imem_rvalid) p_pend = 0;
      else if (p_pend) p_cnt--;
      if (m_req && imem_gnt) begin p_pend = 1; p_addr = old_pc; p_cnt = $urandom_range(2); end

      @(negedge clk);
    end
`ifdef IFETCH_PERF_EN
    check("rnd.fetched", PerfFetched, 32'(m_fetch));
    check("rnd.killed",  PerfKilled,  32'(m_kill));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
